// File: rtl/switch_poll_ctrl_if.sv
// Avalon-MM read-only master bundle between the switch poll sequencer and the PIO slave.
interface switch_poll_ctrl_if;
  logic [1:0]  m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;

  modport master (
    output m_address,
    output m_read,
    input  m_waitrequest,
    input  m_readdata,
    input  m_readdatavalid
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_waitrequest,
    output m_readdata,
    output m_readdatavalid
  );
endinterface

// File: rtl/switch_poll_ctrl.sv
// Switch PIO poll sequencer: periodic Avalon-MM reads, whole-vector debounce, change events.
// Define SWITCH_POLL_IRQ_EN to add the registered irq output.
module switch_poll_ctrl #(
  parameter int unsigned POLL_CYCLES      = 50000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter int unsigned SW_ADDR          = 0,
  parameter int unsigned RD_TIMEOUT       = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  switch_poll_ctrl_if.master  m,
  output logic [7:0]          sw_state,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [7:0]          evt_mask,
  output logic [7:0]          evt_state,
  output logic                overflow,
  output logic                rd_err,
  input  logic                clr_flags
`ifdef SWITCH_POLL_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int unsigned TimerW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned ToW    = $clog2(RD_TIMEOUT + 1);
  localparam int unsigned CntW   = $clog2(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {StIdle, StRead, StWaitData, StUpdate} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        sample_q, sample_d;
  logic [7:0]        cand_q, cand_d;
  logic [7:0]        sw_q, sw_d;
  logic              evt_valid_q, evt_valid_d;
  logic [7:0]        evt_mask_q, evt_mask_d;
  logic [7:0]        evt_state_q, evt_state_d;
  logic              overflow_q, overflow_d;
  logic              rd_err_q, rd_err_d;
  logic              commit;
  logic              xfer;
  logic [7:0]        diff;

  logic unused_readdata;
  assign unused_readdata = ^m.m_readdata[31:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      to_q        <= '0;
      cnt_q       <= '0;
      sample_q    <= '0;
      cand_q      <= '0;
      sw_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_mask_q  <= '0;
      evt_state_q <= '0;
      overflow_q  <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      to_q        <= to_d;
      cnt_q       <= cnt_d;
      sample_q    <= sample_d;
      cand_q      <= cand_d;
      sw_q        <= sw_d;
      evt_valid_q <= evt_valid_d;
      evt_mask_q  <= evt_mask_d;
      evt_state_q <= evt_state_d;
      overflow_q  <= overflow_d;
      rd_err_q    <= rd_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    to_d        = to_q;
    cnt_d       = cnt_q;
    sample_d    = sample_q;
    cand_d      = cand_q;
    sw_d        = sw_q;
    evt_valid_d = evt_valid_q;
    evt_mask_d  = evt_mask_q;
    evt_state_d = evt_state_q;
    // A set in the same cycle overrides the clear below.
    overflow_d  = overflow_q & ~clr_flags;
    rd_err_d    = rd_err_q & ~clr_flags;
    m.m_read    = 1'b0;
    m.m_address = 2'b00;
    commit      = 1'b0;
    xfer        = evt_valid_q & evt_ready;
    diff        = sw_q ^ cand_q;

    if (xfer) begin
      evt_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (!enable) begin
          timer_d = '0;
        end else if (timer_q == TimerW'(POLL_CYCLES - 1)) begin
          timer_d = '0;
          state_d = StRead;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StRead: begin
        m.m_read    = 1'b1;
        m.m_address = 2'(SW_ADDR);
        if (!m.m_waitrequest) begin
          to_d    = '0;
          state_d = StWaitData;
        end
      end
      StWaitData: begin
        if (m.m_readdatavalid) begin
          sample_d = m.m_readdata[7:0];
          state_d  = StUpdate;
        end else if (to_q == ToW'(RD_TIMEOUT)) begin
          rd_err_d = 1'b1;
          state_d  = StIdle;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StUpdate: begin
        state_d = StIdle;
        if (sample_q != cand_q) begin
          cand_d = sample_q;
          cnt_d  = '0;
        end else begin
          if (cnt_q != CntW'(DEBOUNCE_SAMPLES - 1)) begin
            cnt_d = cnt_q + CntW'(1);
          end
          commit = (cnt_d == CntW'(DEBOUNCE_SAMPLES - 1)) && (cand_q != sw_q);
        end
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      sw_d        = cand_q;
      evt_valid_d = 1'b1;
      evt_state_d = cand_q;
      // Unaccepted event: merge change bits so no toggle is lost.
      if (evt_valid_q && !evt_ready) begin
        evt_mask_d = evt_mask_q | diff;
        overflow_d = 1'b1;
      end else begin
        evt_mask_d = diff;
      end
    end
  end

  assign sw_state  = sw_q;
  assign evt_valid = evt_valid_q;
  assign evt_mask  = evt_mask_q;
  assign evt_state = evt_state_q;
  assign overflow  = overflow_q;
  assign rd_err    = rd_err_q;

`ifdef SWITCH_POLL_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= evt_valid_q | overflow_q | rd_err_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_switch_poll_ctrl.sv
// Directed bench for switch_poll_ctrl with a sample-history event model and a bus-slave responder.
module tb_switch_poll_ctrl;
  localparam int POLL = 8;
  localparam int DEB  = 4;
  localparam int TO   = 15;
  localparam int ADDR = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       evt_ready = 1'b0;
  logic       clr_flags = 1'b0;
  logic [7:0] sw_state, evt_mask, evt_state;
  logic       evt_valid, overflow, rd_err;
`ifdef SWITCH_POLL_IRQ_EN
  logic       irq;
`endif

  switch_poll_ctrl_if bus ();

  switch_poll_ctrl #(
    .POLL_CYCLES      (POLL),
    .DEBOUNCE_SAMPLES (DEB),
    .SW_ADDR          (ADDR),
    .RD_TIMEOUT       (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .m         (bus),
    .sw_state  (sw_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_mask  (evt_mask),
    .evt_state (evt_state),
    .overflow  (overflow),
    .rd_err    (rd_err),
    .clr_flags (clr_flags)
`ifdef SWITCH_POLL_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave responder controls
  int         wait_cycles = 0;
  int         rd_lat = 1;
  bit         withhold = 1'b0;
  logic [7:0] sw_val = 8'h00;
  logic [7:0] script[$];
  int         deliveries = 0;
  logic       acc_seen = 1'b0;
  logic       stalled = 1'b0;

  initial begin
    int ws_cnt;
    int lat_cnt;
    bit pend;
    logic [7:0] d;
    ws_cnt = 0;
    lat_cnt = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      bus.m_readdatavalid = 1'b0;
      bus.m_readdata = 32'hA5C3_E100;
      if (acc_seen && !withhold) begin
        pend = 1'b1;
        lat_cnt = 0;
      end
      if (pend) begin
        lat_cnt++;
        if (lat_cnt >= rd_lat) begin
          pend = 1'b0;
          d = (script.size() > 0) ? script.pop_front() : sw_val;
          bus.m_readdatavalid = 1'b1;
          bus.m_readdata = {24'hA5C3E1, d};
          deliveries++;
        end
      end
      if (bus.m_read && ws_cnt < wait_cycles) begin
        bus.m_waitrequest = 1'b1;
        ws_cnt++;
      end else begin
        bus.m_waitrequest = 1'b0;
        ws_cnt = 0;
      end
    end
  end

  // Behavioural model: commit = last DEB delivered samples identical and unlike sw_state.
  bit         started = 1'b0;
  logic       m_valid, m_ovf, m_rerr, irq_exp;
  logic [7:0] m_mask, m_state, m_sw;
  logic [7:0] hist[$];

  initial begin
    bit outst, due, commit, same, xfer;
    int wcnt;
    logic [7:0] due_val, nv, dv;
    logic ovf_n, rerr_n;
    outst = 0; due = 0; wcnt = 0; due_val = 0; nv = 0;
    m_valid = 0; m_ovf = 0; m_rerr = 0; m_mask = 0; m_state = 0; m_sw = 0; irq_exp = 0;
    forever begin
      @(posedge clk);
      acc_seen = bus.m_read && !bus.m_waitrequest && !reset;
      stalled  = bus.m_read && bus.m_waitrequest && !reset;
      irq_exp  = !reset && (m_valid || m_ovf || m_rerr);
      if (reset) begin
        started = 1'b1;
        outst = 0; due = 0; wcnt = 0;
        hist.delete();
        m_valid = 0; m_ovf = 0; m_rerr = 0; m_mask = 0; m_state = 0; m_sw = 0;
      end else begin
        xfer = m_valid && evt_ready;
        ovf_n = m_ovf && !clr_flags;
        rerr_n = m_rerr && !clr_flags;
        commit = 0;
        if (due) begin
          hist.push_back(due_val);
          if (hist.size() > DEB) void'(hist.pop_front());
          if (hist.size() == DEB) begin
            same = 1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
            if (same && hist[0] != m_sw) begin
              commit = 1;
              nv = hist[0];
            end
          end
          due = 0;
        end
        if (commit) begin
          dv = m_sw ^ nv;
          if (m_valid && !evt_ready) begin
            m_mask = m_mask | dv;
            ovf_n = 1;
          end else begin
            m_mask = dv;
          end
          m_state = nv;
          m_sw = nv;
          m_valid = 1;
        end else if (xfer) begin
          m_valid = 0;
        end
        if (outst) begin
          wcnt++;
          if (bus.m_readdatavalid) begin
            due = 1;
            due_val = bus.m_readdata[7:0];
            outst = 0;
          end else if (wcnt == TO + 1) begin
            rerr_n = 1;
            outst = 0;
          end
        end
        if (acc_seen) begin
          outst = 1;
          wcnt = 0;
        end
        m_ovf = ovf_n;
        m_rerr = rerr_n;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("sw_state", sw_state, m_sw);
        chk("evt_valid", evt_valid, m_valid);
        chk("evt_mask", evt_mask, m_mask);
        chk("evt_state", evt_state, m_state);
        chk("overflow", overflow, m_ovf);
        chk("rd_err", rd_err, m_rerr);
        if (bus.m_read) chk("m_address", bus.m_address, ADDR);
        else chk("m_address_idle", bus.m_address, 0);
        if (stalled) chk("read_held", {bus.m_read, bus.m_address}, {1'b1, 2'(ADDR)});
`ifdef SWITCH_POLL_IRQ_EN
        chk("irq", irq, irq_exp);
`endif
      end
    end
  end

  function automatic logic getsig(input int sel);
    case (sel)
      0: return evt_valid;
      1: return overflow;
      2: return rd_err;
      default: return bus.m_read;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input int max, input string name,
                          output int waited);
    waited = 0;
    while (getsig(sel) !== lvl && waited < max) begin
      @(negedge clk);
      waited++;
    end
    chk(name, getsig(sel), lvl);
  endtask

  task automatic wait_deliv(input int target, input string name);
    int k;
    k = 0;
    while (deliveries < target && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(name, deliveries, target);
  endtask

  initial begin
    int w, last, nreads, held, base;
    logic prevm;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;

    // Idle polling of constant 0x00: period 8 idle + read + data + update
    last = -1; nreads = 0; prevm = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.m_read && !prevm) begin
        if (last >= 0) chk("poll_period", i - last, 11);
        else chk("first_read", i, 7);
        last = i;
        nreads++;
      end
      prevm = bus.m_read;
    end
    chk("reads_in_100", nreads, 9);
    chk("idle_evt_valid", evt_valid, 0);
    chk("idle_sw_state", sw_state, 8'h00);

    // 0x5A commit, then accept
    sw_val = 8'h5A;
    wait_for(0, 1'b1, 80, "evt_5a", w);
    chk("sw_5a", sw_state, 8'h5A);
    chk("mask_5a", evt_mask, 8'h5A);
    chk("state_5a", evt_state, 8'h5A);
    evt_ready = 1'b1;
    @(negedge clk);
    chk("accept_drop", evt_valid, 0);

    // Back to 0x00 accepted, then merge 0x01 and 0x03 while pending
    sw_val = 8'h00;
    wait_for(0, 1'b1, 80, "evt_00", w);
    chk("mask_00", evt_mask, 8'h5A);
    @(negedge clk);
    chk("accept_00", evt_valid, 0);
    evt_ready = 1'b0;
    sw_val = 8'h01;
    wait_for(0, 1'b1, 80, "evt_01", w);
    chk("mask_01", evt_mask, 8'h01);
    chk("state_01", evt_state, 8'h01);
    sw_val = 8'h03;
    wait_for(1, 1'b1, 80, "ovf_set", w);
    chk("mask_merge", evt_mask, 8'h03);
    chk("state_merge", evt_state, 8'h03);
    chk("sw_03", sw_state, 8'h03);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("ovf_clr", overflow, 0);
    chk("valid_after_clr", evt_valid, 1);

    // Glitch sequence from a settled 0x00
    evt_ready = 1'b1;
    @(negedge clk);
    chk("drain_03", evt_valid, 0);
    sw_val = 8'h00;
    wait_for(0, 1'b1, 80, "evt_back_00", w);
    chk("mask_back_00", evt_mask, 8'h03);
    @(negedge clk);
    evt_ready = 1'b0;
    base = deliveries;
    script.push_back(8'h10); script.push_back(8'h10); script.push_back(8'h00);
    script.push_back(8'h10); script.push_back(8'h10); script.push_back(8'h10);
    script.push_back(8'h10);
    sw_val = 8'h10;
    wait_deliv(base + 6, "glitch_samples");
    repeat (3) @(negedge clk);
    chk("glitch_no_commit", evt_valid, 0);
    chk("glitch_sw", sw_state, 8'h00);
    wait_for(0, 1'b1, 30, "glitch_commit", w);
    chk("glitch_mask", evt_mask, 8'h10);
    chk("glitch_state", evt_state, 8'h10);
    chk("glitch_ovf", overflow, 0);

    // Stalled read, then a read with no data
    evt_ready = 1'b1;
    @(negedge clk);
    wait_cycles = 5;
    withhold = 1'b1;
    wait_for(3, 1'b1, 30, "stall_read_issue", w);
    held = 0;
    while (bus.m_read && held < 20) begin
      @(negedge clk);
      held++;
    end
    chk("read_hold_cycles", held, 6);
    wait_for(2, 1'b1, 30, "rd_err_set", w);
    chk("timeout_wait", w, 16);
    chk("idle_after_timeout", bus.m_read, 0);
    withhold = 1'b0;
    wait_cycles = 0;
    wait_for(3, 1'b1, 20, "poll_after_timeout", w);
    chk("poll_after_timeout_gap", w, 8);
    base = deliveries;
    wait_deliv(base + 1, "read_after_timeout");
    chk("rd_err_sticky", rd_err, 1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("rd_err_clr", rd_err, 0);

    // Reset while awaiting data; late 0xFF must be ignored
    wait_for(3, 1'b1, 30, "read_before_reset", w);
    sw_val = 8'hFF;
    rd_lat = 3;
    base = deliveries;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    repeat (6) @(negedge clk);
    chk("late_rdv_sent", deliveries - base, 1);
    chk("rst_sw_state", sw_state, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_mask", evt_mask, 0);
    chk("rst_evt_state", evt_state, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_m_read", bus.m_read, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end
endmodule
